axis_i2c_top: RTL and testbench

- Single-byte I2C master driven by an AXI-Stream command port.
- Each accepted AXIS word is one I2C transaction: START, 7-bit address + R/W, one data byte written or read, STOP.
- Read data is returned on a valid-qualified byte output.
- Sits between an AXIS command source (CPU/FSM) and the board-level open-drain SDA/SCL pins.

---
 rtl/axis_i2c_pkg.sv | 26 ++
 rtl/axis_i2c_top_if.sv | 23 ++
 rtl/axis_i2c_top_clk_gen.sv | 34 +++
 rtl/axis_i2c_top.sv | 138 +++++++++++++
 tb/tb_axis_i2c_top.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_i2c_pkg.sv
// Shared types and constants for the AXIS-driven single-byte I2C master.
package axis_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        STOP
    } state_t;

    // Command word layout: [15:9] address, [8] R/W (1 = read), [7:0] write data
    localparam int unsigned CMD_ADDR_MSB = 15;
    localparam int unsigned CMD_RW       = 8;
    localparam int unsigned CMD_DATA_MSB = 7;

    function automatic int unsigned qtr_cycles(input int unsigned main_clk,
                                               input int unsigned i2c_clk);
        return main_clk / (4 * i2c_clk);
    endfunction

endpackage

// File: rtl/axis_i2c_top_if.sv
// AXIS command channel and the pin-level bundle seen by the board/bench.
interface axis_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

interface axis_i2c_top_if;
    logic       clk_i;
    logic       arstn_i;
    logic       en_i;
    logic       i2c_scl_o;
    logic [7:0] i2c_tdata_o;
    logic       i2c_tvalid_o;

    modport master (output clk_i, output arstn_i, output en_i,
                    input i2c_scl_o, input i2c_tdata_o, input i2c_tvalid_o);
    modport slave  (input clk_i, input arstn_i, input en_i,
                    output i2c_scl_o, output i2c_tdata_o, output i2c_tvalid_o);
endinterface

// File: rtl/axis_i2c_top_clk_gen.sv
// Quarter-SCL-period tick generator with a 2-bit quarter phase; idle while run is low.
module i2c_clk_gen
    import axis_i2c_pkg::*;
#(
    parameter int unsigned MAIN_CLK = 100_000_000,
    parameter int unsigned I2C_CLK  = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int unsigned QTR = qtr_cycles(MAIN_CLK, I2C_CLK);
    localparam int unsigned CW  = $clog2(QTR);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(QTR - 1));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axis_i2c_top.sv
// Single-byte I2C master: one AXIS command word becomes START, addr+R/W, one data byte, STOP.
module axis_i2c_top
    import axis_i2c_pkg::*;
#(
    parameter int unsigned MAIN_CLK = 100_000_000,
    parameter int unsigned I2C_CLK  = 200_000
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       en_i,
    inout  wire        i2c_sda_io,
    output logic       i2c_scl_o,
    output logic [7:0] i2c_tdata_o,
    output logic       i2c_tvalid_o,
    axis_if.slave      s_axis
);

    state_t     state, state_nxt;
    logic       tick;
    logic [1:0] phase;
    logic       end_bit, smp, accept, sda_in;
    logic       scl_nxt, sda_low_nxt;
    logic       sda_low_q1, sda_low_q2;
    logic [7:0] tx_sr, rx_sr, data_q;
    logic [2:0] bitcnt;
    logic       rw_q, ack_q;

    i2c_clk_gen #(.MAIN_CLK(MAIN_CLK), .I2C_CLK(I2C_CLK)) u_clk_gen (
        .clk   (clk_i),
        .rst   (arstn_i),
        .run   (state != IDLE),
        .tick  (tick),
        .phase (phase)
    );

    assign s_axis.tready = (state == IDLE) && en_i && !arstn_i;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign end_bit       = tick && (phase == 2'd3);
    assign smp           = tick && (phase == 2'd2);
    assign sda_in        = i2c_sda_io;
    // SDA is delayed one cycle behind SCL so data never moves on the SCL falling edge.
    assign i2c_sda_io    = sda_low_q2 ? 1'b0 : 1'bz;

    always_ff @(posedge clk_i) begin
        if (arstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        scl_nxt     = 1'b1;
        sda_low_nxt = 1'b0;
        unique case (state)
            IDLE: if (accept) state_nxt = START;
            START: begin
                scl_nxt     = (phase != 2'd3);
                sda_low_nxt = (phase != 2'd0);
                if (end_bit) state_nxt = ADDR;
            end
            ADDR: begin
                scl_nxt     = phase[1];
                sda_low_nxt = !tx_sr[7];
                if (end_bit && bitcnt == 3'd7) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_nxt = phase[1];
                if (end_bit) state_nxt = ack_q ? STOP : (rw_q ? RD_DATA : WR_DATA);
            end
            WR_DATA: begin
                scl_nxt     = phase[1];
                sda_low_nxt = !tx_sr[7];
                if (end_bit && bitcnt == 3'd7) state_nxt = WR_ACK;
            end
            WR_ACK: begin
                scl_nxt = phase[1];
                if (end_bit) state_nxt = STOP;
            end
            RD_DATA: begin
                scl_nxt = phase[1];
                if (end_bit && bitcnt == 3'd7) state_nxt = RD_ACK;
            end
            RD_ACK: begin
                scl_nxt = phase[1];
                if (end_bit) state_nxt = STOP;
            end
            STOP: begin
                scl_nxt     = phase[1];
                sda_low_nxt = (phase != 2'd3);
                if (end_bit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arstn_i) begin
            i2c_scl_o    <= 1'b1;
            sda_low_q1   <= 1'b0;
            sda_low_q2   <= 1'b0;
            i2c_tdata_o  <= '0;
            i2c_tvalid_o <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            data_q       <= '0;
            bitcnt       <= '0;
            rw_q         <= 1'b0;
            ack_q        <= 1'b1;
        end else begin
            i2c_scl_o    <= scl_nxt;
            sda_low_q1   <= sda_low_nxt;
            sda_low_q2   <= sda_low_q1;
            i2c_tvalid_o <= 1'b0;
            if (accept) begin
                tx_sr  <= s_axis.tdata[CMD_ADDR_MSB:CMD_RW];
                rw_q   <= s_axis.tdata[CMD_RW];
                data_q <= s_axis.tdata[CMD_DATA_MSB:0];
                bitcnt <= '0;
            end
            if (smp) begin
                ack_q <= sda_in;
                if (state == RD_DATA) rx_sr <= {rx_sr[6:0], sda_in};
            end
            if (end_bit) begin
                if (state == ADDR || state == WR_DATA) begin
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                    bitcnt <= bitcnt + 3'd1;
                end
                if (state == RD_DATA) bitcnt <= bitcnt + 3'd1;
                if (state == ADDR_ACK) tx_sr <= data_q;
                if (state == RD_ACK) begin
                    i2c_tdata_o  <= rx_sr;
                    i2c_tvalid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_i2c_top.sv
// Directed bench for axis_i2c_top with a bit-level I2C slave model on the SDA/SCL pins.
module tb_axis_i2c_top;
    import axis_i2c_pkg::*;

    localparam int unsigned MAIN_CLK = 8_000_000;
    localparam int unsigned I2C_CLK  = 200_000;
    localparam int unsigned QTR      = qtr_cycles(MAIN_CLK, I2C_CLK);
    localparam int unsigned LIM      = 200 * QTR;

    axis_if         s_axis ();
    axis_i2c_top_if pins ();

    logic clk = 1'b0;
    logic drv = 1'b0;
    wire  sda;
    pullup (sda);
    assign sda = drv ? 1'b0 : 1'bz;
    assign pins.clk_i = clk;
    always #5 clk = ~clk;

    axis_i2c_top #(.MAIN_CLK(MAIN_CLK), .I2C_CLK(I2C_CLK)) dut (
        .clk_i        (pins.clk_i),
        .arstn_i      (pins.arstn_i),
        .en_i         (pins.en_i),
        .i2c_sda_io   (sda),
        .i2c_scl_o    (pins.i2c_scl_o),
        .i2c_tdata_o  (pins.i2c_tdata_o),
        .i2c_tvalid_o (pins.i2c_tvalid_o),
        .s_axis       (s_axis)
    );

    int unsigned n_checks = 0, n_fail = 0;
    int unsigned hi_chg = 0, pulses = 0;
    logic [7:0]  cap = '0;
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0]  s_addr, s_data;
    logic        s_mack;
    int unsigned s_hi;
    bit          tmo = 1'b0;

    // SDA edges while SCL is high are START/STOP conditions; data bits must never cause them.
    always @(negedge clk) begin
        if (pins.i2c_scl_o && prev_scl && sda !== prev_sda) hi_chg <= hi_chg + 1;
        if (pins.i2c_tvalid_o) begin
            pulses <= pulses + 1;
            cap    <= pins.i2c_tdata_o;
        end
        prev_scl <= pins.i2c_scl_o;
        prev_sda <= sda;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_scl(input logic lvl);
        int unsigned n = 0;
        while (pins.i2c_scl_o !== lvl && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) tmo = 1'b1;
    endtask

    task automatic wait_cond(input bit want_start);
        logic prev = want_start;
        bit   found = 1'b0;
        int unsigned n = 0;
        while (!found && n < LIM) begin
            @(negedge clk);
            n++;
            if (pins.i2c_scl_o && prev == want_start && sda == !want_start) found = 1'b1;
            prev = sda;
        end
        if (!found) tmo = 1'b1;
    endtask

    task automatic slot(input logic drive_low, output logic b);
        wait_scl(1'b0);
        drv = drive_low;
        wait_scl(1'b1);
        b = sda;
    endtask

    task automatic slave(input bit ack_a, input bit ack_d, input logic [7:0] rd);
        logic b;
        int unsigned base;
        s_addr = '0;
        s_data = '0;
        s_mack = 1'b0;
        base   = hi_chg;
        wait_cond(1'b1);
        for (int i = 0; i < 8; i++) begin
            slot(1'b0, b);
            s_addr = {s_addr[6:0], b};
        end
        slot(ack_a, b);
        if (ack_a) begin
            for (int i = 0; i < 8; i++) begin
                slot(s_addr[0] && !rd[7-i], b);
                s_data = {s_data[6:0], b};
            end
            slot(!s_addr[0] && ack_d, b);
            s_mack = b;
        end
        wait_scl(1'b0);
        drv = 1'b0;
        wait_cond(1'b0);
        @(negedge clk);
        s_hi = hi_chg - base;
    endtask

    task automatic wait_ready(output int unsigned busy);
        busy = 0;
        while (!s_axis.tready && busy < LIM) begin
            @(negedge clk);
            busy++;
        end
        if (busy >= LIM) tmo = 1'b1;
    endtask

    task automatic xfer(input logic [15:0] cmd, output int unsigned busy);
        int unsigned n;
        s_axis.tdata  = cmd;
        s_axis.tvalid = 1'b1;
        wait_ready(n);
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        wait_ready(busy);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned busy, busy2, gap, lat, bad, p0, k;
        logic [7:0] a1, d1;
        pins.arstn_i  = 1'b1;
        pins.en_i     = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_scl", pins.i2c_scl_o, 1);
        check("rst_sda", sda, 1);
        check("rst_tdata", pins.i2c_tdata_o, 0);
        check("rst_tvalid", pins.i2c_tvalid_o, 0);
        check("rst_tready", s_axis.tready, 0);
        pins.arstn_i = 1'b0;
        pins.en_i    = 1'b1;
        @(negedge clk);
        check("idle_tready", s_axis.tready, 1);

        // Write 0x50 <- 0xA5, both bytes ACKed
        p0 = pulses;
        fork
            slave(1'b1, 1'b1, 8'h00);
            xfer(16'hA0A5, busy);
        join
        check("wr_addr", s_addr, 8'hA0);
        check("wr_data", s_data, 8'hA5);
        check("wr_ack", s_mack, 0);
        check("wr_busy", busy, 80 * QTR);
        check("wr_no_pulse", pulses - p0, 0);
        check("wr_sda_hi_edges", s_hi, 2);

        // Read 0x50 -> 0x3C, master NACKs
        p0 = pulses;
        fork
            slave(1'b1, 1'b0, 8'h3C);
            xfer(16'hA100, busy);
        join
        check("rd_addr", s_addr, 8'hA1);
        check("rd_line", s_data, 8'h3C);
        check("rd_master_nack", s_mack, 1);
        check("rd_pulses", pulses - p0, 1);
        check("rd_cap", cap, 8'h3C);
        check("rd_tdata", pins.i2c_tdata_o, 8'h3C);
        check("rd_busy", busy, 80 * QTR);

        // Address NACK: 11 bit periods, no data phase
        p0 = pulses;
        fork
            slave(1'b0, 1'b0, 8'h00);
            xfer(16'h5A5A, busy);
        join
        check("nack_addr", s_addr, 8'h5A);
        check("nack_busy", busy, 44 * QTR);
        check("nack_no_pulse", pulses - p0, 0);
        check("nack_sda_hi_edges", s_hi, 2);

        // Enable gating
        pins.en_i     = 1'b0;
        s_axis.tdata  = 16'hA2C3;
        s_axis.tvalid = 1'b1;
        bad = 0;
        repeat (4 * QTR) begin
            @(negedge clk);
            if (s_axis.tready || !pins.i2c_scl_o || !sda) bad++;
        end
        check("gate_quiet", bad, 0);
        fork
            slave(1'b1, 1'b1, 8'h00);
            begin
                pins.en_i = 1'b1;
                #1;
                check("gate_ready", s_axis.tready, 1);
                @(negedge clk);
                s_axis.tvalid = 1'b0;
                lat = 1;
                while (sda === 1'b1 && lat < LIM) begin
                    @(negedge clk);
                    lat++;
                end
                check("gate_start_lat", lat, QTR + 3);
                wait_ready(busy);
            end
        join
        check("gate_addr", s_addr, 8'hA2);
        check("gate_data", s_data, 8'hC3);

        // Reset during WR_DATA; slave ACK driven by cycle count
        s_axis.tdata  = 16'hA0A5;
        s_axis.tvalid = 1'b1;
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        for (k = 1; k < 45 * QTR; k++) begin
            if (k == 33 * QTR) drv = 1'b1;
            if (k == 40 * QTR + 1) drv = 1'b0;
            @(negedge clk);
        end
        check("rst_in_wrdata_sda", sda, 0);
        pins.arstn_i = 1'b1;
        @(negedge clk);
        check("mid_rst_scl", pins.i2c_scl_o, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_tvalid", pins.i2c_tvalid_o, 0);
        check("mid_rst_tready", s_axis.tready, 0);
        pins.arstn_i = 1'b0;
        #1;
        check("post_rst_tready", s_axis.tready, 1);
        bad = 0;
        repeat (2 * QTR) begin
            @(negedge clk);
            if (!pins.i2c_scl_o || !sda) bad++;
        end
        check("post_rst_no_stop", bad, 0);

        // Back-to-back writes with tvalid held
        fork
            begin
                slave(1'b1, 1'b1, 8'h00);
                a1 = s_addr;
                d1 = s_data;
                slave(1'b1, 1'b1, 8'h00);
            end
            begin
                s_axis.tdata  = 16'hA05A;
                s_axis.tvalid = 1'b1;
                @(negedge clk);
                s_axis.tdata = 16'hA4E7;
                wait_ready(busy);
                gap = 0;
                while (s_axis.tready && gap < LIM) begin
                    @(negedge clk);
                    gap++;
                end
                s_axis.tvalid = 1'b0;
                wait_ready(busy2);
            end
        join
        check("b2b_addr1", a1, 8'hA0);
        check("b2b_data1", d1, 8'h5A);
        check("b2b_addr2", s_addr, 8'hA4);
        check("b2b_data2", s_data, 8'hE7);
        check("b2b_busy1", busy, 80 * QTR);
        check("b2b_gap", gap, 1);
        check("b2b_busy2", busy2, 80 * QTR);
        check("timeouts", tmo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
